uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter BAUD_RATE, default 9600: serial bit rate in bits/s.
REQ-002 The block SHALL have parameter CLOCK_HZ, default 50_000_000: clock frequency in Hz.
REQ-003 The block SHALL have parameter STOP_BITS, default 1: stop bits per frame, valid range 1..2.
REQ-004 The block SHALL have parameter N_BITS, default 8: data bits per frame, valid range 5..8.
REQ-005 The block SHALL have port clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port partida, input, 1 bit: request to enqueue dados, sampled on each rising edge.
REQ-008 The block SHALL have port dados, input, N_BITS bits: byte to transmit, captured when partida is accepted.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port pronto, output, 1 bit: one-cycle pulse marking frame completion.
REQ-011 The block SHALL have port ocupado, output, 1 bit: high while a frame is being shifted out (states START..FIM).
REQ-012 The block SHALL have port cheio, output, 1 bit: holding buffer occupied.
REQ-013 The block SHALL have port db_estado, output, 4 bits: encoded FSM state for the debug display.

Function
REQ-014 The block SHALL define CLK_P_BIT = CLOCK_HZ / BAUD_RATE (integer division; 5208 at defaults) as bit period in clock cycles.
REQ-015 The block SHALL contain one N_BITS holding buffer; a partida sampled while cheio=0 SHALL load dados into it and set cheio=1 on that edge.
REQ-016 The block SHALL ignore partida sampled while cheio=1, including the cycle in which the FSM drains the buffer; dados is not captured.
REQ-017 The block SHALL implement FSM states OCIOSO=0, START=1, DADOS=2, STOP=3, FIM=4, output on db_estado.
REQ-018 In OCIOSO with cheio=1 the FSM SHALL move the buffer into the shift register, clear cheio, and enter START on the same edge.
REQ-019 In START the block SHALL drive tx=0 for exactly CLK_P_BIT cycles, then enter DADOS.
REQ-020 In DADOS the block SHALL send N_BITS bits LSB first, each held CLK_P_BIT cycles, counted by a bit counter, then enter STOP.
REQ-021 In STOP the block SHALL drive tx=1 for STOP_BITS*CLK_P_BIT cycles, then enter FIM.
REQ-022 In FIM the block SHALL hold tx=1 and pronto=1 for exactly one cycle, then enter START if cheio=1 (loading as in REQ-018) else OCIOSO.
REQ-023 The latency from the edge accepting partida (block idle, buffer empty) to tx=0 SHALL be 2 clock cycles.
REQ-024 Back-to-back frames SHALL be separated by exactly one extra high cycle (FIM).
REQ-025 The baud counter SHALL restart at 0 on every state entry and never wrap mid-bit; bit counter width SHALL be ceil(log2(N_BITS+1)).
REQ-026 tx, pronto, ocupado and cheio SHALL be registered (glitch-free).

Reset
REQ-027 On reset=1 at a rising edge the block SHALL, at that edge, set state=OCIOSO, tx=1, pronto=0, ocupado=0, cheio=0, clear counters and shift register; this includes mid-frame reset.
REQ-028 reset SHALL take priority over partida in the same cycle; the byte is discarded.

Verification
REQ-029 The bench SHALL, after reset, pulse partida with dados=0x41 ("A") -> tx low 2 cycles later, then bits 1,0,0,0,0,0,1,0, stop 1, each 5208 cycles; pronto pulses once; ocupado falls with FIM.
REQ-030 The bench SHALL pulse partida with 0x76 ("v") during a frame, then 0x56 ("V") while cheio=1 -> 0x76 sent immediately after current frame with one FIM gap; 0x56 never appears on tx.
REQ-031 The bench SHALL send the sequence "VERILOGUEA" using cheio as flow control -> ten frames, ten pronto pulses, decoded bytes equal to input, each frame (1+8+1)*5208+1 cycles.
REQ-032 The bench SHALL assert reset during the 4th data bit of a frame -> tx=1, db_estado=0, cheio=0 on the next edge; no pronto for that frame; a subsequent byte transmits correctly.
REQ-033 The bench SHALL assert reset and partida in the same cycle -> cheio stays 0, tx stays high for 20000 cycles.
REQ-034 The bench SHALL run with STOP_BITS=2, N_BITS=7 and dados=0x55 -> 7 data bits 1,0,1,0,1,0,1, stop held 2*5208 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding buffer: a byte is accepted while
// the buffer is empty and sent as start, N_BITS data bits (LSB first) and stop bits.
module uart_tx #(
  parameter int BAUD_RATE = 9600,
  parameter int CLOCK_HZ  = 50_000_000,
  parameter int STOP_BITS = 1,
  parameter int N_BITS    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              partida,
  input  logic [N_BITS-1:0] dados,
  output logic              tx,
  output logic              pronto,
  output logic              ocupado,
  output logic              cheio,
  output logic [3:0]        db_estado
);

  localparam int CLK_P_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int STOP_LEN  = STOP_BITS * CLK_P_BIT;
  localparam int CNT_W     = $clog2(STOP_LEN + 1);
  localparam int BIT_W     = $clog2(N_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLK_P_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_LEN - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    START  = 3'd1,
    DADOS  = 3'd2,
    STOP   = 3'd3,
    FIM    = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [N_BITS-1:0] shift_reg;
  logic [N_BITS-1:0] buffer;

  assign db_estado = 4'(state);

  // Outputs are registered from the current state, so tx/pronto/ocupado trail
  // the state register by one cycle; every phase keeps its full length.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= OCIOSO;
      tx        <= 1'b1;
      pronto    <= 1'b0;
      ocupado   <= 1'b0;
      cheio     <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      buffer    <= '0;
    end else begin
      tx      <= 1'b1;
      pronto  <= 1'b0;
      ocupado <= (state != OCIOSO);
      case (state)
        OCIOSO: begin
          if (cheio) begin
            shift_reg <= buffer;
            cheio     <= 1'b0;
            baud_cnt  <= '0;
            state     <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DADOS;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DADOS: begin
          tx <= shift_reg[0];
          if (baud_cnt == BIT_END) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == STOP_END) begin
            baud_cnt <= '0;
            state    <= FIM;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        FIM: begin
          pronto   <= 1'b1;
          baud_cnt <= '0;
          if (cheio) begin
            shift_reg <= buffer;
            cheio     <= 1'b0;
            state     <= START;
          end else begin
            state <= OCIOSO;
          end
        end
        default: state <= OCIOSO;
      endcase
      // Accept and drain are mutually exclusive: accept needs cheio=0, drain cheio=1.
      if (partida && !cheio) begin
        buffer <= dados;
        cheio  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: an 8N1 instance checked by a serial decoder and
// scoreboard queue, plus a 7N2 instance checked inline.
module tb_uart_tx;

  localparam int P = 10;  // CLOCK_HZ / BAUD_RATE used below

  logic       clock;
  logic       reset;
  logic       partida0, partida1;
  logic [7:0] dados0;
  logic [6:0] dados1;
  logic       tx0, pronto0, ocupado0, cheio0;
  logic       tx1, pronto1, ocupado1, cheio1;
  logic [3:0] db0, db1;

  uart_tx #(.BAUD_RATE(100), .CLOCK_HZ(1000), .STOP_BITS(1), .N_BITS(8)) u0 (
    .clock(clock), .reset(reset), .partida(partida0), .dados(dados0),
    .tx(tx0), .pronto(pronto0), .ocupado(ocupado0), .cheio(cheio0), .db_estado(db0)
  );

  uart_tx #(.BAUD_RATE(100), .CLOCK_HZ(1000), .STOP_BITS(2), .N_BITS(7)) u1 (
    .clock(clock), .reset(reset), .partida(partida1), .dados(dados1),
    .tx(tx1), .pronto(pronto1), .ocupado(ocupado1), .cheio(cheio1), .db_estado(db1)
  );

  typedef struct {
    logic [7:0] d;
    bit         b2b;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   pcount = 0;
  bit   mon_en = 1'b1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (pronto0 === 1'b1) pcount = pcount + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit push, input bit b2b);
    dados0   = b;
    partida0 = 1'b1;
    if (push) q.push_back('{d: b, b2b: b2b});
    @(negedge clock);
    partida0 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 50 * P && q.size() != 0; n++) @(negedge clock);
    chk("drain_timeout", q.size(), 0);
    repeat (P) @(negedge clock);
  endtask

  task automatic wait_not_full();
    for (int n = 0; n < 30 * P && cheio0 === 1'b1; n++) @(negedge clock);
    chk("flow_timeout", cheio0, 0);
  endtask

  // Serial decoder for u0: sample mid-bit, pop the scoreboard at mid-stop.
  initial begin
    int         s;
    int         prev;
    logic [7:0] rx;
    exp_t       e;
    prev = -1000000;
    forever begin
      @(negedge clock);
      if (mon_en && tx0 === 1'b0) begin
        s = cyc;
        repeat (P / 2) @(negedge clock);
        chk("start_bit", tx0, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (P) @(negedge clock);
          rx[i] = tx0;
        end
        repeat (P) @(negedge clock);
        chk("stop_bit", tx0, 1);
        chk("frame_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rx_byte", rx, e.d);
          if (e.b2b) chk("frame_gap", s - prev, 10 * P + 1);
        end
        prev = s;
      end
    end
  end

  initial begin
    string      msg;
    int         p0;
    int         s;
    int         n;
    bit         low_seen;
    bit         full_seen;
    logic [6:0] exp7;

    msg = "VERILOGUEA";
    reset = 1'b1; partida0 = 1'b0; partida1 = 1'b0; dados0 = '0; dados1 = '0;
    repeat (3) @(negedge clock);
    chk("rst_tx", tx0, 1);
    chk("rst_state", db0, 0);
    chk("rst_cheio", cheio0, 0);
    chk("rst_ocupado", ocupado0, 0);
    chk("rst_pronto", pronto0, 0);
    reset = 1'b0;
    @(negedge clock);

    // 'A': latency, bit pattern, single pronto
    p0 = pcount;
    send(8'h41, 1, 0);
    chk("accept_cheio", cheio0, 1);
    chk("lat0_tx", tx0, 1);
    @(negedge clock);
    chk("load_state", db0, 1);
    chk("load_cheio", cheio0, 0);
    chk("lat1_tx", tx0, 1);
    @(negedge clock);
    chk("lat2_tx", tx0, 0);
    chk("lat2_ocupado", ocupado0, 1);
    wait_drain();
    chk("a_pronto_cnt", pcount - p0, 1);
    chk("a_ocupado_end", ocupado0, 0);
    chk("a_state_end", db0, 0);

    // 'v' queued mid-frame, 'V' rejected while buffer full
    p0 = pcount;
    send(8'h33, 1, 0);
    for (n = 0; n < 5 && ocupado0 !== 1'b1; n++) @(negedge clock);
    repeat (3 * P) @(negedge clock);
    send(8'h76, 1, 1);
    chk("v_cheio", cheio0, 1);
    send(8'h56, 0, 0);
    chk("V_cheio_hold", cheio0, 1);
    wait_drain();
    repeat (12 * P) @(negedge clock);
    chk("vV_pronto_cnt", pcount - p0, 2);

    // "VERILOGUEA" with cheio as flow control
    p0 = pcount;
    for (int i = 0; i < 10; i++) begin
      wait_not_full();
      send(msg[i], 1, i != 0);
    end
    wait_drain();
    chk("str_pronto_cnt", pcount - p0, 10);

    // reset during the 4th data bit, with a second byte buffered
    mon_en = 1'b0;
    p0 = pcount;
    send(8'hA5, 0, 0);
    for (n = 0; n < 5 && tx0 !== 1'b0; n++) @(negedge clock);
    repeat (P) @(negedge clock);
    send(8'h11, 0, 0);
    repeat (3 * P + 3) @(negedge clock);
    chk("pre_rst_cheio", cheio0, 1);
    chk("pre_rst_state", db0, 2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_tx", tx0, 1);
    chk("mid_rst_state", db0, 0);
    chk("mid_rst_cheio", cheio0, 0);
    chk("mid_rst_ocupado", ocupado0, 0);
    low_seen = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clock);
      if (tx0 !== 1'b1) low_seen = 1'b1;
    end
    chk("mid_rst_idle", low_seen, 0);
    chk("mid_rst_no_pronto", pcount - p0, 0);
    mon_en = 1'b1;
    send(8'h3C, 1, 0);
    wait_drain();
    chk("post_rst_pronto", pcount - p0, 1);

    // reset and partida together: byte discarded
    p0 = pcount;
    reset = 1'b1; partida0 = 1'b1; dados0 = 8'hFF;
    @(negedge clock);
    reset = 1'b0; partida0 = 1'b0;
    chk("rp_cheio", cheio0, 0);
    low_seen = 1'b0;
    full_seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      if (tx0 !== 1'b1) low_seen = 1'b1;
      if (cheio0 !== 1'b0) full_seen = 1'b1;
    end
    chk("rp_tx_idle", low_seen, 0);
    chk("rp_cheio_idle", full_seen, 0);
    chk("rp_no_pronto", pcount - p0, 0);

    // 7N2 instance with 0x55
    exp7 = 7'h55;
    dados1 = exp7; partida1 = 1'b1;
    @(negedge clock);
    partida1 = 1'b0;
    for (n = 0; n < 5 && tx1 !== 1'b0; n++) @(negedge clock);
    s = cyc;
    repeat (P / 2) @(negedge clock);
    chk("n7_start", tx1, 0);
    for (int i = 0; i < 7; i++) begin
      repeat (P) @(negedge clock);
      chk($sformatf("n7_bit%0d", i), tx1, exp7[i]);
    end
    repeat (P) @(negedge clock);
    chk("n7_stop_a", tx1, 1);
    repeat (P) @(negedge clock);
    chk("n7_stop_b", tx1, 1);
    for (n = 0; n < 2 * P && pronto1 !== 1'b1; n++) @(negedge clock);
    chk("n7_pronto_time", cyc - s, 10 * P);
    @(negedge clock);
    chk("n7_pronto_pulse", pronto1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
